// File: rtl/shifter_pkg.sv
// shifter_pkg: shift-op encoding and helpers that place the log2(W) shift layers
// into the STAGES register cuts of pipelined_shifter.
package shifter_pkg;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_SRA = 2'b10,
      SHIFT_ROR = 2'b11
   } shift_op_t;

   function automatic int stage_of_layer(input int k, input int stages, input int amt_width);
      return (k * stages) / amt_width;
   endfunction

   // Highest layer index k with stage_of_layer(k) == s, i.e. ceil((s+1)*A/S) - 1.
   function automatic int last_layer_of_stage(input int s, input int stages, input int amt_width);
      return ((s + 1) * amt_width + stages - 1) / stages - 1;
   endfunction

   function automatic bit is_first_layer(input int k, input int stages, input int amt_width);
      if (k == 0) return 1'b1;
      return stage_of_layer(k - 1, stages, amt_width) != stage_of_layer(k, stages, amt_width);
   endfunction

endpackage

// File: rtl/shifter_layer.sv
// shifter_layer: one combinational barrel layer shifting/rotating by DIST when i_en is set.
module shifter_layer
   import shifter_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DIST       = 1
) (
   input  logic [DATA_WIDTH-1:0] i_data,
   input  shift_op_t             i_op,
   input  logic                  i_en,
   input  logic                  i_fill,
   output logic [DATA_WIDTH-1:0] o_data
);

   always_comb begin
      // NOTE: default assignment first so no path through the case leaves o_data unassigned (no latch).
      o_data = i_data;
      case ({i_op, i_en})
         {SHIFT_SLL, 1'b1}: o_data = {i_data[DATA_WIDTH-DIST-1:0], {DIST{1'b0}}};
         {SHIFT_SRL, 1'b1}: o_data = {{DIST{1'b0}}, i_data[DATA_WIDTH-1:DIST]};
         {SHIFT_SRA, 1'b1}: o_data = {{DIST{i_fill}}, i_data[DATA_WIDTH-1:DIST]};
         {SHIFT_ROR, 1'b1}: o_data = {i_data[DIST-1:0], i_data[DATA_WIDTH-1:DIST]};
         default:           o_data = i_data;
      endcase
   end

endmodule

// File: rtl/pipelined_shifter.sv
// pipelined_shifter: SLL/SRL/SRA/ROR barrel shifter split over STAGES valid/ready register cuts.
// Optional SHIFTER_FLAGS_EN adds registered Zero_out/Carry_out flags.
module pipelined_shifter
   import shifter_pkg::*;
#(
   parameter  int DATA_WIDTH = 32,
   parameter  int STAGES     = 2,
   parameter  int TAG_WIDTH  = 5,
   localparam int AMT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Flush,
   input  logic                  In_valid,
   output logic                  In_ready,
   input  logic [DATA_WIDTH-1:0] Shift_in,
   input  logic [AMT_WIDTH-1:0]  Shift_amount,
   input  logic [1:0]            Shift_op,
   input  logic [TAG_WIDTH-1:0]  Tag_in,
   output logic                  Out_valid,
   input  logic                  Out_ready,
   output logic [DATA_WIDTH-1:0] Shift_out,
`ifdef SHIFTER_FLAGS_EN
   output logic                  Zero_out,
   output logic                  Carry_out,
`endif
   output logic [TAG_WIDTH-1:0]  Tag_out
);

   logic [DATA_WIDTH-1:0] r_data  [STAGES];
   shift_op_t             r_op    [STAGES];
   logic [AMT_WIDTH-1:0]  r_amt   [STAGES];
   logic [TAG_WIDTH-1:0]  r_tag   [STAGES];
   logic                  r_fill  [STAGES];
   logic [STAGES-1:0]     r_valid;

   logic [DATA_WIDTH-1:0] w_in_data   [STAGES];
   shift_op_t             w_in_op     [STAGES];
   logic [AMT_WIDTH-1:0]  w_in_amt    [STAGES];
   logic [TAG_WIDTH-1:0]  w_in_tag    [STAGES];
   logic                  w_in_fill   [STAGES];
   logic [STAGES-1:0]     w_in_valid;
   logic [DATA_WIDTH-1:0] w_stage_out [STAGES];
   logic [DATA_WIDTH-1:0] w_lay_out   [AMT_WIDTH];
   logic [STAGES:0]       w_ready;

`ifdef SHIFTER_FLAGS_EN
   logic                 r_zero;
   logic [STAGES-1:0]    r_carry;
   logic [STAGES-1:0]    w_in_carry;
   logic [STAGES-1:0]    w_carry_next;
   logic                 w_carry_in;
   logic [AMT_WIDTH-1:0] w_sll_idx;
   logic [AMT_WIDTH-1:0] w_srl_idx;

   // W - amt wraps correctly in AMT_WIDTH bits because W is a power of two.
   assign w_sll_idx = AMT_WIDTH'(DATA_WIDTH) - Shift_amount;
   assign w_srl_idx = Shift_amount - AMT_WIDTH'(1);

   always_comb begin
      w_carry_in = 1'b0;
      if (Shift_amount != '0) begin
         case (shift_op_t'(Shift_op))
            SHIFT_SLL:            w_carry_in = Shift_in[w_sll_idx];
            SHIFT_SRL, SHIFT_SRA: w_carry_in = Shift_in[w_srl_idx];
            default:              w_carry_in = 1'b0;
         endcase
      end
   end
`endif

   assign w_ready[STAGES] = Out_ready;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_head
         assign w_in_data[s]  = Shift_in;
         assign w_in_op[s]    = shift_op_t'(Shift_op);
         assign w_in_amt[s]   = Shift_amount;
         assign w_in_tag[s]   = Tag_in;
         assign w_in_fill[s]  = Shift_in[DATA_WIDTH-1];
         assign w_in_valid[s] = In_valid;
`ifdef SHIFTER_FLAGS_EN
         assign w_in_carry[s] = w_carry_in;
`endif
      end else begin : g_body
         assign w_in_data[s]  = r_data[s-1];
         assign w_in_op[s]    = r_op[s-1];
         assign w_in_amt[s]   = r_amt[s-1];
         assign w_in_tag[s]   = r_tag[s-1];
         assign w_in_fill[s]  = r_fill[s-1];
         assign w_in_valid[s] = r_valid[s-1];
`ifdef SHIFTER_FLAGS_EN
         assign w_in_carry[s] = r_carry[s-1];
`endif
      end

      assign w_ready[s]     = !r_valid[s] | w_ready[s+1];
      assign w_stage_out[s] = w_lay_out[last_layer_of_stage(s, STAGES, AMT_WIDTH)];

`ifdef SHIFTER_FLAGS_EN
      // A rotate's carry is the result MSB, known only once every layer has been applied.
      if (s == STAGES - 1) begin : g_ror_carry
         assign w_carry_next[s] = (w_in_op[s] == SHIFT_ROR)
                                ? ((w_in_amt[s] != '0) & w_stage_out[s][DATA_WIDTH-1])
                                : w_in_carry[s];
      end else begin : g_pass_carry
         assign w_carry_next[s] = w_in_carry[s];
      end
`endif
   end

   for (genvar k = 0; k < AMT_WIDTH; k++) begin : g_layer
      localparam int STG = stage_of_layer(k, STAGES, AMT_WIDTH);
      logic [DATA_WIDTH-1:0] w_src;

      if (is_first_layer(k, STAGES, AMT_WIDTH)) begin : g_from_reg
         assign w_src = w_in_data[STG];
      end else begin : g_chain
         assign w_src = w_lay_out[k-1];
      end

      shifter_layer #(
         .DATA_WIDTH (DATA_WIDTH),
         .DIST       (1 << k)
      ) u_layer (
         .i_data (w_src),
         .i_op   (w_in_op[STG]),
         .i_en   (w_in_amt[STG][k]),
         .i_fill (w_in_fill[STG]),
         .o_data (w_lay_out[k])
      );
   end

   // NOTE: data registers are reset too, so Shift_out/Tag_out read 0 straight out of reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         for (int s = 0; s < STAGES; s++) begin
            r_data[s] <= '0;
            r_op[s]   <= SHIFT_SLL;
            r_amt[s]  <= '0;
            r_tag[s]  <= '0;
            r_fill[s] <= 1'b0;
         end
`ifdef SHIFTER_FLAGS_EN
         r_zero  <= 1'b1;
         r_carry <= '0;
`endif
      end else if (Flush) begin
         r_valid <= '0;
      end else begin
         for (int s = 0; s < STAGES; s++) begin
            if (w_ready[s]) begin
               r_valid[s] <= w_in_valid[s];
               // Bubbles leave the payload untouched; only valid data is captured.
               if (w_in_valid[s]) begin
                  r_data[s] <= w_stage_out[s];
                  r_op[s]   <= w_in_op[s];
                  r_amt[s]  <= w_in_amt[s];
                  r_tag[s]  <= w_in_tag[s];
                  r_fill[s] <= w_in_fill[s];
`ifdef SHIFTER_FLAGS_EN
                  r_carry[s] <= w_carry_next[s];
                  if (s == STAGES - 1) r_zero <= (w_stage_out[s] == '0);
`endif
               end
            end
         end
      end
   end

   assign In_ready  = w_ready[0] & !Flush;
   assign Out_valid = r_valid[STAGES-1] & !Flush;
   assign Shift_out = r_data[STAGES-1];
   assign Tag_out   = r_tag[STAGES-1];
`ifdef SHIFTER_FLAGS_EN
   assign Zero_out  = r_zero;
   assign Carry_out = r_carry[STAGES-1];
`endif

endmodule
